// File: rtl/delay_arb_pkg.sv
// Shared types and default sizing for the delay_arb block: FSM state
// encoding and the default requester count / counter width.
package delay_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int CBITS_DEF = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req at or above ptr,
// wrapping modulo NREQ. Returns the winner as one-hot and as an index.
module rr_pick
    import delay_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NREQ);
    endfunction

    // Scanning from the farthest candidate back toward ptr lets the nearest
    // requester overwrite the others, so no priority flag is needed.
    always_comb begin
        // NOTE: every output gets a value before the loop, so no path can
        // leave one unassigned and infer a latch.
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap(int'(ptr) + k)]) begin
                winner                       = '0;
                winner[wrap(int'(ptr) + k)]  = 1'b1;
                idx                          = wrap(int'(ptr) + k);
                valid                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_arb.sv
// Round-robin arbiter for one shared delay counter: the winner's length is
// latched, counted out, and completion signalled with a one-cycle done pulse.
// Define DELAY_ARB_ASSERT_EN to compile in the SVA property set.
module delay_arb
    import delay_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [CBITS-1:0]      cnt
);

    localparam int PW = $clog2(NREQ);

    state_t                state, state_nx;
    logic [PW-1:0]         ptr, ptr_nx;
    logic [PW-1:0]         owner, owner_nx, owner_inc;
    logic [CBITS-1:0]      lat_len, lat_len_nx, cnt_nx;
    logic [NREQ-1:0]       gnt_nx, done_nx;
    logic [NREQ-1:0]       pick_onehot;
    logic [PW-1:0]         pick_idx;
    logic                  pick_valid;
    logic [NREQ*CBITS-1:0] len_sh;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign len_sh    = len >> (int'(pick_idx) * CBITS);
    assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        owner_nx   = owner;
        lat_len_nx = lat_len;
        cnt_nx     = cnt;
        gnt_nx     = gnt;
        done_nx    = done;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_nx   = pick_idx;
                    lat_len_nx = len_sh[CBITS-1:0];
                    cnt_nx     = '0;
                    gnt_nx     = pick_onehot;
                    state_nx   = RUN;
                end
            end
            RUN: begin
                // Owner dropped its request: abandon quietly, no done pulse.
                if (!req[owner]) begin
                    gnt_nx   = '0;
                    ptr_nx   = owner_inc;
                    state_nx = IDLE;
                end else if (cnt == lat_len) begin
                    done_nx  = gnt;
                    gnt_nx   = '0;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                done_nx  = '0;
                ptr_nx   = owner_inc;
                state_nx = IDLE;
            end
            default: begin
                gnt_nx   = '0;
                done_nx  = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            lat_len <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
        end else begin
            // NOTE: non-blocking updates make every register see the values
            // from before this edge, independent of statement order.
            state   <= state_nx;
            ptr     <= ptr_nx;
            owner   <= owner_nx;
            lat_len <= lat_len_nx;
            cnt     <= cnt_nx;
            gnt     <= gnt_nx;
            done    <= done_nx;
        end
    end

`ifdef DELAY_ARB_ASSERT_EN
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_done_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(|gnt && |done));

    for (genvar i = 0; i < NREQ; i++) begin : g_req_props
        a_done_after_gnt: assert property (@(posedge clk) disable iff (!rst_n)
            done[i] |-> $past(gnt[i]));
        p_live: assert property (@(posedge clk) disable iff (!rst_n)
            (s_eventually always req[i]) implies (s_eventually done[i]));
    end
`endif

endmodule

// File: tb/tb_delay_arb.sv
// Scoreboard bench for delay_arb: a transaction-level model predicts grant
// and completion events into a queue; a negedge monitor pops and compares.
module tb_delay_arb;
    import delay_arb_pkg::*;

    localparam int N  = 4;
    localparam int CB = 14;
    localparam logic [N*CB-1:0] MASK = (N*CB)'((1 << CB) - 1);

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*CB-1:0] len;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          busy;
    logic [CB-1:0] cnt;

    delay_arb #(.NREQ(N), .CBITS(CB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .cnt   (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit req_bit(input int i);
        return ((req >> i) & N'(1)) != '0;
    endfunction

    function automatic int len_of(input int i);
        logic [N*CB-1:0] t;
        t = len >> (i * CB);
        return int'(t[CB-1:0]);
    endfunction

    task automatic set_len(input int i, input int v);
        len = (len & ~(MASK << (i * CB))) | (((N*CB)'(v)) & MASK) << (i * CB);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit is_end;
        int idx;
        bit with_done;
        int cyc;
    } ev_t;

    ev_t expq[$];
    int  cyc = 0;
    int  m_owner, m_ptr, m_len, m_start, m_hold, m_free_at, m_done_cyc, m_w;

    task automatic end_txn(input bit with_done);
        expq.push_back('{1'b1, m_owner, with_done, cyc});
        m_hold = cyc - m_start - 1;
        m_ptr  = (m_owner + 1) % N;
        if (with_done) begin
            m_done_cyc = cyc;
            m_free_at  = cyc + 2;
        end
        m_owner = -1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expq.delete();
            m_owner    = -1;
            m_ptr      = 0;
            m_hold     = 0;
            m_free_at  = 0;
            m_done_cyc = -10;
        end else begin
            cyc++;
            if (m_owner >= 0) begin
                if (!req_bit(m_owner))
                    end_txn(1'b0);
                else if (cyc == m_start + m_len + 1)
                    end_txn(1'b1);
            end else if (cyc >= m_free_at && req != '0) begin
                m_w = -1;
                for (int k = 0; k < N; k++)
                    if (m_w < 0 && req_bit((m_ptr + k) % N)) m_w = (m_ptr + k) % N;
                m_owner = m_w;
                m_len   = len_of(m_w);
                m_start = cyc;
                expq.push_back('{1'b0, m_w, 1'b0, cyc});
            end
        end
    end

    // ---------------- monitor ----------------
    logic [N-1:0] prev_gnt = '0;
    ev_t e;
    int  rise_cyc   = 0;
    int  done_count = 0;
    int  max_cnt    = 0;
    int  gnt_log[$];
    int  dur_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gnt = '0;
        end else begin
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
            check("cnt", 32'(cnt), 32'(m_owner >= 0 ? cyc - m_start : m_hold));
            check("busy", 32'(busy), 32'(m_owner >= 0 || m_done_cyc == cyc));
            check("gnt_done_overlap", 32'(gnt & done), 32'd0);
            if (gnt != prev_gnt) begin
                if (expq.size() == 0) begin
                    check("unexpected_gnt_change", 32'(gnt), 32'(prev_gnt));
                end else begin
                    e = expq.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    if (prev_gnt == '0) begin
                        check("rise_kind", 32'(e.is_end), 32'd0);
                        check("gnt_value", 32'(gnt), 32'd1 << e.idx);
                        gnt_log.push_back(e.idx);
                        rise_cyc = cyc;
                    end else begin
                        check("end_kind", 32'(e.is_end), 32'd1);
                        check("gnt_fall", 32'(gnt), 32'd0);
                        check("done_value", 32'(done), e.with_done ? (32'd1 << e.idx) : 32'd0);
                        if (done != '0) begin
                            done_count++;
                            dur_log.push_back(cyc - rise_cyc);
                        end
                    end
                end
            end else if (done != '0) begin
                check("stray_done", 32'(done), 32'd0);
            end
            prev_gnt = gnt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done == '0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done != '0), 32'd1);
    endtask

    task automatic wait_cnt(input int v, input int budget, input string name);
        int n = 0;
        while (!(gnt != '0 && int'(cnt) == v) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(cnt), 32'(v));
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (done_count < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done_count >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    int exp032[5] = '{0, 1, 2, 3, 0};
    int exp036[4] = '{0, 3, 0, 3};
    int b;
    int bd;

    initial begin
        rst_n = 1'b1;
        req   = '0;
        len   = '0;
        #1 rst_n = 1'b0;
        #3;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cnt", 32'(cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // single requester, len 5
        set_len(1, 5);
        req = 4'b0010;
        tick();
        check("r031_gnt", 32'(gnt), 32'b0010);
        wait_done(50, "r031_done_timeout");
        check("r031_done", 32'(done), 32'b0010);
        check("r031_duration", dur_log[$], 32'd6);
        req = '0;
        tick();
        tick();
        check("r031_busy_low", 32'(busy), 32'd0);

        // all four, zero length, from reset
        do_reset();
        b = gnt_log.size();
        bd = done_count;
        for (int i = 0; i < N; i++) set_len(i, 0);
        req = 4'b1111;
        wait_dones(bd + 5, 100, "r032_timeout");
        req = '0;
        wait_idle(20);
        for (int k = 0; k < 5; k++) begin
            check("r032_order", gnt_log[b+k], exp032[k]);
            check("r032_duration", dur_log[bd+k], 32'd1);
        end

        // abandon mid-count, next search starts above the abandoner
        set_len(2, 100);
        req = 4'b0100;
        wait_cnt(10, 50, "r033_cnt");
        req = '0;
        tick();
        check("r033_abort_gnt", 32'(gnt), 32'd0);
        check("r033_abort_done", 32'(done), 32'd0);
        set_len(0, 1);
        set_len(1, 1);
        set_len(3, 1);
        req = 4'b1011;
        tick();
        check("r033_next_gnt", 32'(gnt), 32'b1000);
        req = '0;
        wait_idle(20);

        // full-scale length, no wrap
        max_cnt = 0;
        set_len(0, 16383);
        req = 4'b0001;
        wait_done(17000, "r034_done_timeout");
        check("r034_duration", dur_log[$], 32'd16384);
        check("r034_cnt_peak", max_cnt, 32'd16383);
        req = '0;
        wait_idle(20);

        // async reset mid-run
        set_len(0, 50);
        req = 4'b0001;
        wait_cnt(7, 50, "r035_cnt");
        #2 rst_n = 1'b0;
        #1;
        check("r035_gnt_async", 32'(gnt), 32'd0);
        check("r035_done_async", 32'(done), 32'd0);
        check("r035_busy_async", 32'(busy), 32'd0);
        check("r035_cnt_async", 32'(cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("r035_regrant", 32'(gnt), 32'b0001);
        req = '0;
        wait_idle(20);

        // two requesters alternate; len0 wiggles while 0 owns the counter
        do_reset();
        b = gnt_log.size();
        bd = done_count;
        set_len(0, 2);
        set_len(3, 2);
        req = 4'b1001;
        for (int n = 0; n < 200 && done_count < bd + 4; n++) begin
            tick();
            if (gnt[0]) set_len(0, $urandom_range(0, 40));
            else        set_len(0, 2);
        end
        check("r036_timeout", 32'(done_count >= bd + 4), 32'd1);
        req = '0;
        set_len(0, 2);
        wait_idle(20);
        for (int k = 0; k < 4; k++) begin
            check("r036_order", gnt_log[b+k], exp036[k]);
            check("r036_duration", dur_log[bd+k], 32'd3);
        end

        // random traffic: raise, abandon, re-request after done, move len
        for (int n = 0; n < 800; n++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_bit(i)) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_len(i, $urandom_range(0, 6));
                        req = req | (N'(1) << i);
                    end
                end else if (((done >> i) & N'(1)) != '0) begin
                    if ($urandom_range(0, 1) == 0) req = req & ~(N'(1) << i);
                end else if ($urandom_range(0, 39) == 0) begin
                    req = req & ~(N'(1) << i);
                end else if ($urandom_range(0, 9) == 0) begin
                    set_len(i, $urandom_range(0, 6));
                end
            end
        end
        req = '0;
        wait_idle(50);
        tick();
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
